// File: rtl/colorbar_demo_sequencer.sv
// Frame-based demo scheduler for the colour-bar generator: steps through four
// overlay/scroll phases from vsync frame counts or a pushbutton, and keeps the scroll offset.
//
// state        | meaning
// PH_BARS      | plain bars, no overlay, nothing scrolls
// PH_ID        | ID overlay band shown, static
// PH_ID_SCROLL | ID overlay band scrolls with scroll_offset
// PH_ALL       | overlay and bars both scroll
module colorbar_demo_sequencer #(
  parameter int PHASE_FRAMES     = 120,
  parameter int H_ACTIVE         = 640,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       auto_en,
  input  logic       hold,
  input  logic       next_btn,
  input  logic [1:0] speed,
  output logic [1:0] phase,
  output logic       id_overlay_en,
  output logic       bar_scroll_en,
  output logic       id_scroll_en,
  output logic [9:0] scroll_offset,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    PH_BARS      = 2'd0,
    PH_ID        = 2'd1,
    PH_ID_SCROLL = 2'd2,
    PH_ALL       = 2'd3
  } phase_e;

  localparam logic       VSYNC_IDLE = (VSYNC_ACTIVE_LOW != 0);
  localparam logic [7:0] CNT_LAST   = 8'(PHASE_FRAMES - 1);
  localparam logic [10:0] H_MOD     = 11'(H_ACTIVE);

  phase_e      phase_q, phase_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [9:0]  offset_q, offset_d;
  logic        frame_tick_q, frame_tick_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic        btn_sync1_q, btn_sync1_d;
  logic        btn_sync2_q, btn_sync2_d;
  logic        btn_prev_q, btn_prev_d;
  logic        overlay_q, overlay_d;
  logic        bar_scroll_q, bar_scroll_d;
  logic        id_scroll_q, id_scroll_d;

  logic        adv_req;
  logic        tick_run;
  logic        auto_adv;
  logic        advance;
  logic [10:0] step;
  logic [10:0] off_sum;
  logic [9:0]  off_wrap;

  always_comb begin
    vsync_prev_d = vsync;
    // Polarity is normalised by XOR with the idle level so the edge detect is polarity-free.
    frame_tick_d = (vsync ^ VSYNC_IDLE) & ~(vsync_prev_q ^ VSYNC_IDLE);

    btn_sync1_d = next_btn;
    btn_sync2_d = btn_sync1_q;
    btn_prev_d  = btn_sync2_q;
    adv_req     = btn_sync2_q & ~btn_prev_q;

    tick_run = frame_tick_q & ~hold;
    auto_adv = tick_run & auto_en & (frame_cnt_q == CNT_LAST);
    advance  = adv_req | auto_adv;

    phase_d = advance ? phase_e'(phase_q + 2'd1) : phase_q;

    frame_cnt_d = frame_cnt_q;
    if (advance)
      frame_cnt_d = 8'd0;
    else if (tick_run && auto_en)
      frame_cnt_d = frame_cnt_q + 8'd1;

    case (speed)
      2'd0:    step = 11'd1;
      2'd1:    step = 11'd2;
      2'd2:    step = 11'd5;
      default: step = 11'd10;
    endcase
    off_sum  = {1'b0, offset_q} + step;
    off_wrap = (off_sum >= H_MOD) ? 10'(off_sum - H_MOD) : off_sum[9:0];

    // Clearing on entry to PH_BARS wins over a same-cycle scroll update.
    offset_d = offset_q;
    if (advance && phase_d == PH_BARS)
      offset_d = 10'd0;
    else if (tick_run && (phase_q == PH_ID_SCROLL || phase_q == PH_ALL))
      offset_d = off_wrap;

    overlay_d    = (phase_d != PH_BARS);
    bar_scroll_d = (phase_d == PH_ALL);
    id_scroll_d  = (phase_d == PH_ID_SCROLL) || (phase_d == PH_ALL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= PH_BARS;
      frame_cnt_q  <= 8'd0;
      offset_q     <= 10'd0;
      frame_tick_q <= 1'b0;
      vsync_prev_q <= VSYNC_IDLE;
      btn_sync1_q  <= 1'b0;
      btn_sync2_q  <= 1'b0;
      btn_prev_q   <= 1'b0;
      overlay_q    <= 1'b0;
      bar_scroll_q <= 1'b0;
      id_scroll_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      frame_cnt_q  <= frame_cnt_d;
      offset_q     <= offset_d;
      frame_tick_q <= frame_tick_d;
      vsync_prev_q <= vsync_prev_d;
      btn_sync1_q  <= btn_sync1_d;
      btn_sync2_q  <= btn_sync2_d;
      btn_prev_q   <= btn_prev_d;
      overlay_q    <= overlay_d;
      bar_scroll_q <= bar_scroll_d;
      id_scroll_q  <= id_scroll_d;
    end
  end

  assign phase         = phase_q;
  assign id_overlay_en = overlay_q;
  assign bar_scroll_en = bar_scroll_q;
  assign id_scroll_en  = id_scroll_q;
  assign scroll_offset = offset_q;
  assign frame_tick    = frame_tick_q;

endmodule

// File: tb/tb_colorbar_demo_sequencer.sv
// Self-checking bench for colorbar_demo_sequencer: table-driven auto sequence plus
// hand-written button, hold, wrap, reset and coincident-advance sequences.
module tb_colorbar_demo_sequencer;

  localparam int PF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b1;
  logic       auto_en = 1'b0;
  logic       hold = 1'b0;
  logic       next_btn = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [1:0] phase;
  logic       id_overlay_en, bar_scroll_en, id_scroll_en;
  logic [9:0] scroll_offset;
  logic       frame_tick;

  colorbar_demo_sequencer #(
    .PHASE_FRAMES(PF), .H_ACTIVE(640), .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .auto_en(auto_en), .hold(hold),
    .next_btn(next_btn), .speed(speed), .phase(phase),
    .id_overlay_en(id_overlay_en), .bar_scroll_en(bar_scroll_en),
    .id_scroll_en(id_scroll_en), .scroll_offset(scroll_offset),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       h;
    logic [1:0] sp;
    logic [1:0] ph;
    logic [9:0] off;
  } vec_t;

  typedef struct {
    logic [1:0] ph;
    logic [9:0] off;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[17];

  int n_checks = 0;
  int n_errors = 0;
  int m_ph = 0;
  int m_cnt = 0;
  int m_off = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [2:0] en_of(input logic [1:0] p);
    case (p)
      2'd0:    return 3'b000;
      2'd1:    return 3'b100;
      2'd2:    return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  function automatic int next_off(input int o, input logic [1:0] sp);
    int st;
    int s;
    st = (sp == 2'd0) ? 1 : (sp == 2'd1) ? 2 : (sp == 2'd2) ? 5 : 10;
    s = o + st;
    return (s >= 640) ? s - 640 : s;
  endfunction

  task automatic model_tick(input logic a, input logic h, input logic [1:0] sp);
    logic adv;
    int   old;
    adv = a && !h && (m_cnt == PF - 1);
    old = m_ph;
    if (adv) m_ph = (m_ph + 1) % 4;
    if (adv) m_cnt = 0;
    else if (a && !h) m_cnt++;
    if (adv && m_ph == 0) m_off = 0;
    else if (!h && old >= 2) m_off = next_off(m_off, sp);
  endtask

  task automatic model_press();
    m_ph = (m_ph + 1) % 4;
    m_cnt = 0;
    if (m_ph == 0) m_off = 0;
  endtask

  task automatic push_model();
    exp_t e;
    e.ph = 2'(m_ph);
    e.off = 10'(m_off);
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({nm, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({nm, "_phase"}, phase, e.ph);
    check({nm, "_offset"}, scroll_offset, e.off);
    check({nm, "_enables"}, {id_overlay_en, bar_scroll_en, id_scroll_en}, en_of(e.ph));
  endtask

  task automatic run_frame(input logic a, input logic h, input logic [1:0] sp,
                           input logic use_tbl, input logic [1:0] t_ph,
                           input logic [9:0] t_off, input string nm);
    exp_t e;
    int   ticks;
    @(negedge clk);
    auto_en = a;
    hold = h;
    speed = sp;
    model_tick(a, h, sp);
    if (use_tbl) begin
      e.ph = t_ph;
      e.off = t_off;
      exp_q.push_back(e);
    end else begin
      push_model();
    end
    ticks = 0;
    vsync = 1'b0;
    repeat (4) begin @(negedge clk); ticks += int'(frame_tick); end
    vsync = 1'b1;
    repeat (6) begin @(negedge clk); ticks += int'(frame_tick); end
    check({nm, "_tick_count"}, ticks, 1);
    check_out(nm);
  endtask

  task automatic press_btn(input string nm);
    @(negedge clk);
    next_btn = 1'b1;
    model_press();
    push_model();
    repeat (4) @(negedge clk);
    next_btn = 1'b0;
    repeat (4) @(negedge clk);
    check_out(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph_col[17] = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0};
    int off_col[17] = '{0,0,0,0,0,0,0,0,1,2,3,4,5,6,7,0,0};
    for (int i = 0; i < 17; i++)
      tbl[i] = '{1'b1, 1'b0, 2'd0, 2'(ph_col[i]), 10'(off_col[i])};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_phase", phase, 0);
    check("rst_offset", scroll_offset, 0);
    check("rst_enables", {id_overlay_en, bar_scroll_en, id_scroll_en}, 0);
    check("rst_tick", frame_tick, 0);
    reset = 1'b0;

    // First vsync edge after release: one-cycle tick, one clk after the sampled edge.
    repeat (2) @(negedge clk);
    check("tick_idle", frame_tick, 0);
    vsync = 1'b0;
    @(negedge clk);
    check("tick_first", frame_tick, 1);
    @(negedge clk);
    check("tick_width", frame_tick, 0);
    vsync = 1'b1;
    repeat (4) @(negedge clk);

    // Automatic four-phase sequence, PF frames per phase.
    for (int i = 0; i < 17; i++)
      run_frame(tbl[i].a, tbl[i].h, tbl[i].sp, 1'b1, tbl[i].ph, tbl[i].off, $sformatf("auto%0d", i));

    // Long button press in manual mode: exactly one advance, 3 clks after the press.
    @(negedge clk);
    auto_en = 1'b0;
    next_btn = 1'b1;
    @(negedge clk); check("btn_lat1", phase, 0);
    @(negedge clk); check("btn_lat2", phase, 0);
    @(negedge clk); check("btn_lat3", phase, 1);
    repeat (47) @(negedge clk);
    check("btn_held", phase, 1);
    next_btn = 1'b0;
    repeat (5) @(negedge clk);
    check("btn_release", phase, 1);
    model_press();

    for (int i = 0; i < 5; i++) run_frame(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 10'd0, "manual_frame");
    press_btn("press_ph2");
    press_btn("press_ph3");

    // Offset wrap in PH3: 635 + 10 -> 5, then 638 + 5 -> 3.
    for (int i = 0; i < 63; i++) run_frame(1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 10'd0, "wrap_a");
    for (int i = 0; i < 5; i++) run_frame(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 10'd0, "wrap_b");
    check("pre_wrap_635", scroll_offset, 635);
    run_frame(1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 10'd0, "wrap_c");
    check("wrap_635_plus10", scroll_offset, 5);
    for (int i = 0; i < 63; i++) run_frame(1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 10'd0, "wrap_d");
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 10'd0, "wrap_e");
    check("pre_wrap_638", scroll_offset, 638);
    run_frame(1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 10'd0, "wrap_f");
    check("wrap_638_plus5", scroll_offset, 3);

    // Asynchronous reset mid-phase, checked before any clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_phase", phase, 0);
    check("async_rst_offset", scroll_offset, 0);
    check("async_rst_enables", {id_overlay_en, bar_scroll_en, id_scroll_en}, 0);
    @(negedge clk);
    reset = 1'b0;
    m_ph = 0; m_cnt = 0; m_off = 0;

    // Hold in PH2 freezes count and offset; ticks keep pulsing.
    @(negedge clk);
    auto_en = 1'b1;
    press_btn("hold_to_ph1");
    press_btn("hold_to_ph2");
    run_frame(1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 10'd0, "pre_hold_a");
    run_frame(1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 10'd0, "pre_hold_b");
    for (int i = 0; i < 10; i++) run_frame(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 10'd0, "held");
    run_frame(1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 10'd0, "post_hold_c");
    check("post_hold_still_ph2", phase, 2);
    run_frame(1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 10'd0, "post_hold_d");
    check("post_hold_expiry_ph3", phase, 3);

    // Button still advances while hold is asserted.
    @(negedge clk);
    hold = 1'b1;
    press_btn("hold_press_ph0");
    press_btn("hold_press_ph1");
    press_btn("hold_press_ph2");
    press_btn("hold_press_ph3");
    check("hold_press_reached_ph3", phase, 3);
    @(negedge clk);
    hold = 1'b0;

    // Button request coinciding with the auto-expiry tick in PH1: single step.
    press_btn("co_to_ph0");
    press_btn("co_to_ph1");
    for (int i = 0; i < 3; i++) run_frame(1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 10'd0, "co_pre");
    @(negedge clk);
    auto_en = 1'b1; hold = 1'b0; speed = 2'd1;
    next_btn = 1'b1;
    model_tick(1'b1, 1'b0, 2'd1);
    push_model();
    @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    next_btn = 1'b0;
    repeat (6) @(negedge clk);
    check_out("coincident");
    for (int i = 0; i < 3; i++) run_frame(1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 10'd0, "co_post");
    check("co_cnt_cleared_still_ph2", phase, 2);
    run_frame(1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 10'd0, "co_expiry");
    check("co_expiry_ph3", phase, 3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
